// File: rtl/flurbie_pkg.sv
// Shared types and constants for the flurbie decode stage: instruction field
// layout, opcode set, register file types and the decoded micro-op.
package flurbie_pkg;

  localparam int NREGS   = 16;
  localparam int WIDTH   = 32;
  localparam int REG_W   = 4;
  localparam int OPC_W   = 4;
  localparam int IMM_W   = 16;
  localparam int OPC_LSB = 28;
  localparam int RD_LSB  = 24;
  localparam int RA_LSB  = 20;
  localparam int RB_LSB  = 16;
  localparam int IMM_LSB = 0;

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(NREGS - 1);

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_ADDI = 4'd6,
    OP_LDI  = 4'd7,
    OP_LD   = 4'd8,
    OP_ST   = 4'd9,
    OP_BEQ  = 4'd10
  } opcode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef logic [WIDTH-1:0]   regval_t;
  typedef regval_t [NREGS-1:0] regfile_t;

  // Opcode is kept as raw bits so undefined encodings pass through unchanged.
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    regval_t          a;
    regval_t          b;
    regval_t          imm;
    regval_t          pc;
    logic             writes_rd;
  } decode_out_t;

  // Returns {uses_ra, uses_rb, writes_rd}; undefined opcodes behave as NOP.
  function automatic logic [2:0] uses_operands(input opcode_e opcode);
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 3'b111;
      OP_ADDI, OP_LD:                        return 3'b101;
      OP_LDI:                                return 3'b001;
      OP_ST, OP_BEQ:                         return 3'b110;
      default:                               return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Busy bit per architectural register for in-flight writes; the read ports
// ignore a busy bit that writeback is clearing in the same cycle.
module decode_scoreboard
  import flurbie_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic [REG_W-1:0] rd_a_idx,
  input  logic [REG_W-1:0] rd_b_idx,
  output logic             busy_a,
  output logic             busy_b
);

  logic [NREGS-1:0] busy;

  // Set has priority over a same-cycle clear; r0 is never tracked.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (set_en && (set_idx == REG_W'(i)) && (i != 0)) begin
          busy[i] <= 1'b1;
        end else if (clr_en && (clr_idx == REG_W'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  assign busy_a = busy[rd_a_idx] && !(clr_en && (clr_idx == rd_a_idx));
  assign busy_b = busy[rd_b_idx] && !(clr_en && (clr_idx == rd_b_idx));

endmodule

// File: rtl/decode.sv
// Decode stage: field split, operand read with writeback bypass, RAW stall via
// scoreboard, PC-write flush handling and a registered micro-op to execute.
module decode
  import flurbie_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  regval_t          in_instr,
  input  regval_t          in_pc,
  input  regfile_t         registers,
  input  logic             hold_in,
  output logic             hold_out,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_reg,
  input  regval_t          wb_value,
  input  logic             has_flushed,
  output logic             is_pc_changing,
  output logic             early_flush,
  output logic             out_valid,
  output logic [OPC_W-1:0] out_opcode,
  output logic [REG_W-1:0] out_rd,
  output regval_t          out_a,
  output regval_t          out_b,
  output regval_t          out_imm,
  output regval_t          out_pc,
  output logic             out_writes_rd
);

  logic [OPC_W-1:0] opc;
  logic [REG_W-1:0] rd, ra, rb;
  logic             uses_ra, uses_rb, writes_rd, writes_rd_eff;
  logic             busy_a, busy_b, stall, issue, bubble, sb_set;
  state_e           state, state_nxt;
  decode_out_t      uop, uop_p0;
  logic             vld_p0, pcchg_p0;

  function automatic regval_t read_operand(
    input logic [REG_W-1:0] idx,
    input regval_t          pc,
    input regfile_t         rf,
    input logic             wv,
    input logic [REG_W-1:0] wr,
    input regval_t          wval
  );
    if (idx == '0)       return '0;
    if (idx == PC_IDX)   return pc + regval_t'(4);
    if (wv && wr == idx) return wval;
    return rf[idx];
  endfunction

  function automatic regval_t sext_imm(input logic signed [IMM_W-1:0] imm);
    logic signed [WIDTH-1:0] ext;
    ext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    return regval_t'(ext);
  endfunction

  assign opc = in_instr[OPC_LSB +: OPC_W];
  assign rd  = in_instr[RD_LSB +: REG_W];
  assign ra  = in_instr[RA_LSB +: REG_W];
  assign rb  = in_instr[RB_LSB +: REG_W];

  assign {uses_ra, uses_rb, writes_rd} = uses_operands(opcode_e'(opc));
  assign writes_rd_eff = writes_rd && (rd != '0);
  assign sb_set        = issue && writes_rd_eff;

  decode_scoreboard u_sb (
    .clock    (clock),
    .reset    (reset),
    .set_en   (sb_set),
    .set_idx  (rd),
    .clr_en   (wb_valid),
    .clr_idx  (wb_reg),
    .rd_a_idx (ra),
    .rd_b_idx (rb),
    .busy_a   (busy_a),
    .busy_b   (busy_b)
  );

  always_comb begin
    uop           = '0;
    uop.opcode    = opc;
    uop.rd        = rd;
    uop.a         = read_operand(ra, in_pc, registers, wb_valid, wb_reg, wb_value);
    uop.b         = read_operand(rb, in_pc, registers, wb_valid, wb_reg, wb_value);
    uop.imm       = sext_imm(in_instr[IMM_LSB +: IMM_W]);
    uop.pc        = in_pc;
    uop.writes_rd = writes_rd_eff;
  end

  assign stall    = in_valid && ((uses_ra && busy_a) || (uses_rb && busy_b));
  assign hold_out = stall || hold_in;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    bubble      = 1'b0;
    early_flush = 1'b0;
    case (state)
      ST_RUN: begin
        if (!hold_in) begin
          if (in_valid && !stall) begin
            issue = 1'b1;
            if (writes_rd_eff && (rd == PC_IDX)) state_nxt = ST_FLUSH;
          end else begin
            bubble = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        // Everything fetched before the redirect lands is dropped.
        if (!hold_in) bubble = 1'b1;
        if (has_flushed) begin
          state_nxt   = ST_RUN;
          early_flush = !reset;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // ---- stage p0: registered micro-op handed to execute ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0        <= 1'b0;
      pcchg_p0      <= 1'b0;
      uop_p0        <= '0;
      uop_p0.opcode <= OP_NOP;
    end else begin
      pcchg_p0 <= issue && writes_rd_eff && (rd == PC_IDX);
      if (issue) begin
        vld_p0 <= 1'b1;
        uop_p0 <= uop;
      end else if (bubble) begin
        vld_p0           <= 1'b0;
        uop_p0.writes_rd <= 1'b0;
      end
    end
  end

  assign out_valid      = vld_p0;
  assign is_pc_changing = pcchg_p0;
  assign out_opcode     = uop_p0.opcode;
  assign out_rd         = uop_p0.rd;
  assign out_a          = uop_p0.a;
  assign out_b          = uop_p0.b;
  assign out_imm        = uop_p0.imm;
  assign out_pc         = uop_p0.pc;
  assign out_writes_rd  = uop_p0.writes_rd;

endmodule
